// File: rtl/pipe_mem_stage_ls.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mem_stage_ls
// Description : MEM stage of the 5-stage CPU: EX/MEM register, word-organised
//               data memory, sized loads/stores with extension and misalign trap.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mem_stage_ls #(
    parameter int ADDR_W = 10,
    parameter int REG_W  = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             stall,
    input  logic             flush,
    input  logic             EXwreg,
    input  logic             EXm2reg,
    input  logic             EXwmem,
    input  logic [1:0]       EXsize,
    input  logic             EXunsigned,
    input  logic [REG_W-1:0] EXwn,
    input  logic [31:0]      EXaluResult,
    input  logic [31:0]      EXqb,
    output logic             MEMwreg,
    output logic             MEMm2reg,
    output logic [REG_W-1:0] MEMwn,
    output logic [31:0]      MEMaluResult,
    output logic [31:0]      MEMmemOut,
    output logic             MEMexc,
    output logic [31:0]      MEMfwd
);

    localparam int         c_depth   = 1 << ADDR_W;
    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;
    localparam logic [1:0] c_sz_word = 2'b10;

    logic             r_wreg;
    logic             r_m2reg;
    logic             r_wmem;
    logic [1:0]       r_size;
    logic             r_unsigned;
    logic [REG_W-1:0] r_wn;
    logic [31:0]      r_alu;
    logic [31:0]      r_qb;

    logic [31:0]      r_mem [0:c_depth-1];

    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_lane;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_exc;
    logic [31:0]       w_rword;
    logic [3:0]        w_be;
    logic [31:0]       w_merged;
    logic              w_we;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [31:0]       w_ld_ext;
    logic              w_ld_en;

    // EX/MEM pipeline register: clear/flush insert a bubble, stall holds
    always_ff @(posedge clk) begin
        if (clr || flush) begin
            r_wreg     <= 1'b0;
            r_m2reg    <= 1'b0;
            r_wmem     <= 1'b0;
            r_size     <= c_sz_word;
            r_unsigned <= 1'b0;
            r_wn       <= '0;
            r_alu      <= '0;
            r_qb       <= '0;
        end else if (!stall) begin
            r_wreg     <= EXwreg;
            r_m2reg    <= EXm2reg;
            r_wmem     <= EXwmem;
            r_size     <= EXsize;
            r_unsigned <= EXunsigned;
            r_wn       <= EXwn;
            r_alu      <= EXaluResult;
            r_qb       <= EXqb;
        end
    end

    assign w_idx     = r_alu[ADDR_W+1:2];
    assign w_lane    = r_alu[1:0];
    assign w_is_half = (r_size == c_sz_half);
    assign w_is_word = r_size[1];
    assign w_exc     = (r_m2reg | r_wmem) &
                       ((w_is_half & w_lane[0]) | (w_is_word & (w_lane != 2'b00)));
    assign w_rword   = r_mem[w_idx];

    always_comb begin
        w_be = 4'b0000;
        case (r_size)
            c_sz_byte: w_be = 4'b0001 << w_lane;
            c_sz_half: w_be = w_lane[1] ? 4'b1100 : 4'b0011;
            default:   w_be = 4'b1111;
        endcase
    end

    // Per-lane read-modify-write merge so unselected lanes keep their bytes
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] w_src;
        always_comb begin
            w_src = r_qb[7:0];
            if (w_is_word)
                w_src = r_qb[8*i +: 8];
            else if (w_is_half)
                w_src = r_qb[8*(i%2) +: 8];
        end
        assign w_merged[8*i +: 8] = w_be[i] ? w_src : w_rword[8*i +: 8];
    end

    // A stalled store commits only at its release edge; clr does not gate it
    assign w_we = r_wmem & ~w_exc & ~stall;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    always_comb begin
        w_ld_byte = w_rword[7:0];
        case (w_lane)
            2'd0: w_ld_byte = w_rword[7:0];
            2'd1: w_ld_byte = w_rword[15:8];
            2'd2: w_ld_byte = w_rword[23:16];
            default: w_ld_byte = w_rword[31:24];
        endcase
    end

    assign w_ld_half = w_lane[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_ld_ext = w_rword;
        case (r_size)
            c_sz_byte: w_ld_ext = {{24{w_ld_byte[7] & ~r_unsigned}}, w_ld_byte};
            c_sz_half: w_ld_ext = {{16{w_ld_half[15] & ~r_unsigned}}, w_ld_half};
            default:   w_ld_ext = w_rword;
        endcase
    end

    assign w_ld_en      = r_m2reg & ~w_exc;
    assign MEMmemOut    = w_ld_en ? w_ld_ext : 32'h0000_0000;
    assign MEMexc       = w_exc;
    assign MEMwreg      = r_wreg & ~w_exc;
    assign MEMm2reg     = r_m2reg;
    assign MEMwn        = r_wn;
    assign MEMaluResult = r_alu;
    assign MEMfwd       = r_m2reg ? MEMmemOut : r_alu;

endmodule
`default_nettype wire

// File: doc/pipe_mem_stage_ls.md
# pipe_mem_stage_ls

Parametrised MEM pipeline stage for the 5-stage pipelined CPU: EX/MEM pipeline register with stall and flush control, word-organised data memory, and byte/halfword/word loads and stores with sign/zero extension. Misaligned accesses are detected and suppressed. The stage sits between the EX stage and the MEM/WB register. It also supplies a ready-made forwarding value for the hazard unit.

## Interface
Parameters:
- ADDR_W, 10: word-address bits; memory depth is 2^ADDR_W 32-bit words.
- REG_W, 5: register-index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- stall  in  1  hold the EX/MEM register.
- flush  in  1  load a bubble into the EX/MEM register.
- EXwreg, EXm2reg, EXwmem  in  1 each  register-write, load-select and memory-write controls from EX.
- EXsize  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- EXunsigned  in  1  zero-extend loads (lbu/lhu) when 1.
- EXwn  in  REG_W  destination register.
- EXaluResult  in  32  byte address or ALU result.
- EXqb  in  32  store data.
- MEMwreg, MEMm2reg  out  1  registered controls; MEMwreg is forced 0 on an exception.
- MEMwn  out  REG_W  registered destination.
- MEMaluResult  out  32  registered ALU result.
- MEMmemOut  out  32  aligned, extended load data.
- MEMexc  out  1  misaligned access in the MEM stage.
- MEMfwd  out  32  MEMm2reg ? MEMmemOut : MEMaluResult.

## Operation
- **EX/MEM register update**, priority clr > flush > stall > load:
  - clr or flush: all controls 0, EXsize 10, unsigned 0, wn 0, data fields 0 (bubble).
  - stall: hold the current contents.
  - Otherwise: capture all EX inputs.
- **Memory**:
  - Array of 2^ADDR_W × 32, little-endian byte lanes.
  - Word index = MEMaluResult[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo depth.
  - Memory contents are not affected by clr.
- **Misalignment**: MEMexc = MEMm2reg|MEMwmem, AND (half with a[0]=1, or word with a[1:0]≠0).
- **Store commit**:
  - The write occurs at the rising edge ending the MEM cycle when MEMwmem=1, MEMexc=0 and stall=0. Each store therefore commits exactly once, however long it is stalled.
  - Lane selection uses a = MEMaluResult[1:0].
  - Byte: lane a receives EXqb[7:0] (as registered).
  - Half: lanes a, a+1 (a ∈ {0,2}) receive qb[15:0].
  - Word: all four lanes receive qb.
  - Unselected lanes are preserved.
- **Stall and flush together**: the store in MEM is discarded (never written), because the instruction is killed.
- **Load**:
  - The addressed word is read combinationally.
  - Byte: lane a, sign-extended from bit 7 unless unsigned.
  - Half: lanes a+1:a, sign-extended from bit 15 unless unsigned.
  - Word: the full word.
  - MEMmemOut is 0 when MEMm2reg=0 or MEMexc=1.
- MEMwreg output = registered wreg AND NOT MEMexc.

## Timing
- **Reset**: after a clr edge, MEMwreg=0, MEMm2reg=0, MEMwn=0, MEMaluResult=0, MEMmemOut=0, MEMexc=0, MEMfwd=0.
- **Latency**: EX inputs sampled at edge N appear on the MEM outputs after edge N (one cycle). MEMmemOut, MEMexc and MEMfwd are combinational within that cycle.
- **Store visibility**: a store commits at edge N+1. A load in MEM during that same cycle (impossible back-to-back; it would be the store itself) sees the old data. A load reaching MEM after edge N+1 sees the new data, so a store immediately followed by a load to the same address returns the stored value.
- **Read-during-write**: the combinational read returns pre-write contents until the edge.
- **Stall**: outputs are held stable for the whole stall; no write occurs until the cycle in which stall=0.
- **Reset mid-store**: clr at the commit edge has no priority over the write path. The write still commits if stall=0 and MEMexc=0, since clr only clears the register.

## Test plan
- **Word round-trip**: sw 0x12345678 to address 0x10, then lw 0x10. Required: MEMmemOut=0x12345678, MEMfwd equal, MEMwreg=1.
- **Byte merge and extension**:
  - Preload word 0x00000000 at 0x20; sb 0x80 to 0x22.
  - lw 0x20 → 0x00800000.
  - lb 0x22 → 0xFFFFFF80.
  - lbu 0x22 → 0x00000080.
  - lh 0x22 → 0x00000080.
- **Misalignment**:
  - lw 0x06: MEMexc=1, MEMwreg=0, MEMmemOut=0.
  - sh 0x05 with 0xBEEF: MEMexc=1 and memory unchanged (a later lw 0x04 returns the prior value).
- **Stall**: sw 0xCAFEF00D held in MEM by stall for 3 cycles. Required: outputs stable, exactly one write at the release edge, subsequent lw returns 0xCAFEF00D.
- **Flush**:
  - flush while an lw is entering: next cycle all controls are 0 and MEMfwd=0.
  - flush+stall with a store in MEM: the store is never written.
- **Reset and wrap**:
  - clr mid-stream: all outputs are 0 next cycle and memory contents are retained.
  - Address 4·2^ADDR_W+8 aliases to word 2.
